// File: rtl/scoreboard_hazard_unit_pkg.sv
// Shared constants for the scoreboard hazard unit and for decode, which derives
// issue latencies from the same source.
package scoreboard_hazard_unit_pkg;

  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_REG_AW   = 5;
  localparam int DEF_MAX_LAT  = 34;
  localparam int DEF_CNT_W    = 6;

  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;
  localparam int LAT_MUL  = 3;
  localparam int LAT_DIV  = 34;

endpackage

// File: rtl/scoreboard_hazard_unit_if.sv
// Decode-to-scoreboard issue bus. The master side is decode (or a bench), and
// the slave side is the hazard unit.
interface scoreboard_hazard_unit_if
  import scoreboard_hazard_unit_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int REG_AW   = DEF_REG_AW,
  parameter int CNT_W    = DEF_CNT_W
);
  logic              issue_valid_i;
  logic [REG_AW-1:0] issue_rs1_i;
  logic [REG_AW-1:0] issue_rs2_i;
  logic              issue_use_rs1_i;
  logic              issue_use_rs2_i;
  logic [REG_AW-1:0] issue_rd_i;
  logic              issue_regwrite_i;
  logic [CNT_W-1:0]  issue_lat_i;
  logic              issue_long_i;
  logic [CNT_W-1:0]  issue_occ_i;
  logic              flush_i;
  logic              stall_o;
  logic              issue_fire_o;
  logic [NUM_REGS-1:0] pending_o;
  logic              long_busy_o;

  modport master (
    output issue_valid_i, issue_rs1_i, issue_rs2_i, issue_use_rs1_i, issue_use_rs2_i,
           issue_rd_i, issue_regwrite_i, issue_lat_i, issue_long_i, issue_occ_i, flush_i,
    input  stall_o, issue_fire_o, pending_o, long_busy_o
  );

  modport slave (
    input  issue_valid_i, issue_rs1_i, issue_rs2_i, issue_use_rs1_i, issue_use_rs2_i,
           issue_rd_i, issue_regwrite_i, issue_lat_i, issue_long_i, issue_occ_i, flush_i,
    output stall_o, issue_fire_o, pending_o, long_busy_o
  );
endinterface

// File: rtl/scoreboard_hazard_unit_lat_counter.sv
// Saturating down-counter with load priority. It holds the cycles remaining
// until a result is forwardable, or until the long unit is free.
module sb_lat_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] val_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)              cnt_d = val_i;
    else if (cnt_q != '0)    cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/scoreboard_hazard_unit.sv
// Latency scoreboard between D and E. It detects RAW, WAW and long-unit hazards,
// produces stall_o and issue_fire_o, and tracks per-register countdowns.
module scoreboard_hazard_unit
  import scoreboard_hazard_unit_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int REG_AW   = DEF_REG_AW,
  parameter int MAX_LAT  = DEF_MAX_LAT,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  scoreboard_hazard_unit_if.slave sb
);
  logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
  logic [CNT_W-1:0] busy_cnt;
  logic [CNT_W-1:0] lat_c, occ_c;
  logic raw, waw, st_haz, stall, fire;

  assign lat_c = (sb.issue_lat_i > CNT_W'(MAX_LAT)) ? CNT_W'(MAX_LAT) : sb.issue_lat_i;
  assign occ_c = (sb.issue_occ_i > CNT_W'(MAX_LAT)) ? CNT_W'(MAX_LAT) : sb.issue_occ_i;

  // A count of 0 or 1 means the producer's value is available through forwarding.
  assign raw    = (sb.issue_use_rs1_i && (cnt[sb.issue_rs1_i] > CNT_W'(1))) ||
                  (sb.issue_use_rs2_i && (cnt[sb.issue_rs2_i] > CNT_W'(1)));
  assign waw    = sb.issue_regwrite_i && (sb.issue_rd_i != '0) && (cnt[sb.issue_rd_i] > lat_c);
  assign st_haz = sb.issue_long_i && (busy_cnt != '0);

  assign stall = sb.issue_valid_i && !sb.flush_i && (raw || waw || st_haz);
  assign fire  = sb.issue_valid_i && !sb.flush_i && !stall;

  assign cnt[0] = '0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    sb_lat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .load_i(fire && sb.issue_regwrite_i && (sb.issue_rd_i == REG_AW'(r))),
      .val_i (lat_c),
      .cnt_o (cnt[r])
    );
  end

  sb_lat_counter #(.CNT_W(CNT_W)) u_busy (
    .clk   (clk),
    .rst   (rst),
    .load_i(fire && sb.issue_long_i),
    .val_i (occ_c),
    .cnt_o (busy_cnt)
  );

  always_comb begin
    sb.pending_o = '0;
    for (int r = 0; r < NUM_REGS; r++) sb.pending_o[r] = (cnt[r] != '0);
  end

  assign sb.stall_o      = stall;
  assign sb.issue_fire_o = fire;
  assign sb.long_busy_o  = (busy_cnt != '0);
endmodule

// File: doc/scoreboard_hazard_unit.md
Name: scoreboard_hazard_unit

Overview:
- Parametrised successor to the fixed five-stage hazard logic.
- Tracks per-register result latency with countdown counters, so the pipeline can host variable-latency execute units (loads, multiply, iterative divide) instead of only a one-cycle load-use stall.
- Sits between decode and execute and gates instruction issue from D to E.
- Produces the stall for F/D and the issue strobe.
- Operand forwarding muxes stay outside this block.

Parameters:
NUM_REGS, 32, number of architectural integer registers; register 0 is hardwired zero.
REG_AW, 5, register index width; must equal clog2(NUM_REGS).
MAX_LAT, 34, largest result latency in cycles that any execute unit reports.
CNT_W, 6, counter width; must equal clog2(MAX_LAT+1).

Ports:
clk  in  1  pipeline clock.
rst  in  1  reset, synchronous, active-high.
issue_valid_i  in  1  a valid instruction in D requests issue.
issue_rs1_i  in  REG_AW  source register 1 index.
issue_rs2_i  in  REG_AW  source register 2 index.
issue_use_rs1_i  in  1  the instruction reads rs1.
issue_use_rs2_i  in  1  the instruction reads rs2.
issue_rd_i  in  REG_AW  destination register index.
issue_regwrite_i  in  1  the instruction writes rd.
issue_lat_i  in  CNT_W  cycles from issue until rd is forwardable: ALU=1, load=2, mul/div=n.
issue_long_i  in  1  the instruction uses the shared multi-cycle unit.
issue_occ_i  in  CNT_W  cycles for which the long unit stays occupied.
flush_i  in  1  redirect from EX; kills the instruction in D.
stall_o  out  1  hold the PC and the IF/ID register.
issue_fire_o  out  1  the instruction in D enters E this cycle.
pending_o  out  NUM_REGS  bit r=1 while cnt[r]!=0 (debug/trace).
long_busy_o  out  1  the long unit is occupied.

Behaviour:
- State: cnt[r] of width CNT_W for r=1..NUM_REGS-1; cnt[0] is constant 0. Also a busy_cnt of width CNT_W.
- Reset (rst=1 at a clk edge): every cnt and busy_cnt is 0. Reset takes priority over all other inputs and is also honoured mid-divide. Outputs after reset: stall_o=0, issue_fire_o=0, pending_o=0, long_busy_o=0.
- RAW hazard:
  - raw = (issue_use_rs1_i && cnt[rs1]>1) || (issue_use_rs2_i && cnt[rs2]>1).
  - cnt<=1 means the value reaches the consumer's EX stage through forwarding.
- WAW hazard:
  - waw = issue_regwrite_i && rd!=0 && cnt[rd]>lat_c.
  - lat_c = min(issue_lat_i, MAX_LAT).
  - Purpose: a younger write must never complete before an older one.
- Structural hazard: struct = issue_long_i && busy_cnt!=0.
- Outputs and issue rule:
  - stall_o = issue_valid_i && !flush_i && (raw || waw || struct). Combinational, same cycle.
  - issue_fire_o = issue_valid_i && !flush_i && !stall_o.
  - flush_i wins over stall: stall_o=0 and nothing issues.
- Counter update at each edge, per register r:
  - If issue_fire_o && issue_regwrite_i && rd==r && r!=0: cnt[r] <= lat_c.
  - Else if cnt[r]!=0: cnt[r] <= cnt[r]-1.
  - A new set overrides the decrement in the same cycle.
  - lat_c=0 sets nothing.
  - A write to x0 never marks x0 pending.
- busy_cnt update:
  - If issue_fire_o && issue_long_i: busy_cnt <= min(issue_occ_i, MAX_LAT).
  - Else it decrements toward 0 and saturates at 0.
- long_busy_o = busy_cnt!=0.
- Latency: a register is pending from the edge after issue; pending_o reflects registered state.
- Flush semantics:
  - The flush kills only D.
  - Instructions already issued keep their counters, because older ops still retire.
  - No scoreboard entry is cleared by flush.
- rs1==rs2 and rd==rs both work; the RAW check uses state from before the update.
- Counters never wrap: the decrement is gated by !=0 and the set value is clamped to MAX_LAT.

Decomposition:
- Shared package holds:
  - latency constants: LAT_ALU=1, LAT_LOAD=2, LAT_MUL=3, LAT_DIV=34;
  - the NUM_REGS/REG_AW/CNT_W defaults, so decode derives issue_lat_i from the same source.
- One natural sub-module, sb_lat_counter: a single saturating down-counter with load priority. Instantiate it NUM_REGS-1 times plus once for busy_cnt.

Test Plan:
- Reset with stimulus held active -> stall_o=0, pending_o=0, long_busy_o=0. Then issue rd=5 lat=1 -> pending_o[5]=1 for exactly one cycle.
- ALU back-to-back: issue rd=5 lat=1, next cycle rs1=5 -> stall_o=0 and issue_fire_o=1 both cycles. Load rd=6 lat=2, next cycle rs2=6 -> stall_o=1 for exactly 1 cycle, then fire.
- Divide rd=7 lat=34 occ=34:
  - A consumer of x7 stalls 33 cycles, then fires.
  - An independent ALU op issued meanwhile fires immediately.
  - A second div stalls until long_busy_o falls.
- WAW: div rd=9 lat=10, then ALU rd=9 lat=1 -> stalled until cnt[9]<=1; pending_o[9] stays 1 across the handover. Write to x0 with lat=34 -> never pending, never stalls.
- Flush while stalled on load-use -> stall_o=0, issue_fire_o=0, and no counters change except decrements.
- rst asserted at cycle 5 of a divide -> next cycle all pending_o=0 and long_busy_o=0; a consumer of rd fires without stall.
